// File: rtl/scic_gpio_if.sv
// scic_gpio_if: SCIC data-bus port of the switch/LED peripheral.
//
// Strobe semantics: the master asserts wr_en or rd_en for exactly one cycle
// per access, with addr/wdata valid in that same cycle. There is no
// back-pressure; the slave accepts every strobe. A read answers one cycle
// later with rdata_valid high for exactly one cycle. rdata keeps its last
// value while rdata_valid is low.
interface scic_gpio_if;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, rdata_valid);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, rdata_valid);
endinterface

// File: rtl/scic_gpio.sv
// scic_gpio: memory-mapped switch/LED port for the SCIC core.
// Registers: 0 SW_STATE (RO), 1 LED (RW), 2 CHANGE (W1C), 3 MASK (RW).
// Switches pass through a 2-flop synchroniser, then a debounce stage.
// Build option SCIC_GPIO_DEBOUNCE_EN: when defined, each switch bit needs
// DEBOUNCE_CYCLES stable cycles before it is accepted. When undefined,
// sync2 is accepted every cycle and DEBOUNCE_CYCLES is ignored.
module scic_gpio #(
    parameter int SW_WIDTH        = 4,
    parameter int LED_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  switches,
    scic_gpio_if.slave           bus,
    output logic [LED_WIDTH-1:0] LEDs,
    output logic                 irq
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("scic_gpio: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SW_WIDTH-1:0]  sync1, sync2;
    logic [SW_WIDTH-1:0]  sw_state;
    logic [SW_WIDTH-1:0]  change;
    logic [SW_WIDTH-1:0]  mask;
    logic [LED_WIDTH-1:0] led_r;
    logic [SW_WIDTH-1:0]  accept;     // per-bit: sync2 differs and is taken this edge
    logic [SW_WIDTH-1:0]  clr;        // per-bit W1C clear request
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    // Upper wdata bits beyond a register's width are deliberately dropped.
    assign unused_wdata = ^bus.wdata;

    // Two-flop synchroniser for the raw asynchronous switch levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

`ifdef SCIC_GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [SW_WIDTH];

    // Per-bit stability counters; any re-match with sw_state restarts them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SW_WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < SW_WIDTH; i++) begin
                if (sync2[i] == sw_state[i])  cnt[i] <= '0;
                else if (cnt[i] == CNT_LAST)  cnt[i] <= '0;
                else                          cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // A bit is accepted once it has differed for DEBOUNCE_CYCLES edges
    always_comb begin
        accept = '0;
        for (int i = 0; i < SW_WIDTH; i++)
            accept[i] = (sync2[i] != sw_state[i]) && (cnt[i] == CNT_LAST);
    end
`else
    // Without debounce every difference is taken on the next edge
    always_comb begin
        accept = sync2 ^ sw_state;
    end
`endif

    // Debounced switch state follows sync2 only on accepted bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sw_state <= '0;
        else        sw_state <= (sw_state & ~accept) | (sync2 & accept);
    end

    // W1C clear mask from a CHANGE write
    always_comb begin
        clr = '0;
        if (bus.wr_en && bus.addr == 2'd2) clr = bus.wdata[SW_WIDTH-1:0];
    end

    // Sticky change flags; a set in the same cycle as a clear wins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) change <= '0;
        else        change <= (change & ~clr) | accept;
    end

    // LED and MASK register writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_r <= '0;
            mask  <= '0;
        end else if (bus.wr_en) begin
            if (bus.addr == 2'd1) led_r <= bus.wdata[LED_WIDTH-1:0];
            if (bus.addr == 2'd3) mask  <= bus.wdata[SW_WIDTH-1:0];
        end
    end

    // Read mux sees pre-edge register values, so a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            2'd0:    rd_mux = 32'(sw_state);
            2'd1:    rd_mux = 32'(led_r);
            2'd2:    rd_mux = 32'(change);
            default: rd_mux = 32'(mask);
        endcase
    end

    // Registered read response; rdata holds when no read is issued
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
        end else begin
            bus.rdata_valid <= bus.rd_en;
            if (bus.rd_en) bus.rdata <= rd_mux;
        end
    end

    assign LEDs = led_r;
    assign irq  = |(change & mask);

endmodule

// File: doc/scic_gpio.md
# scic_gpio

Parametrised switch/LED I/O peripheral for the SCIC core. It replaces the fixed 4-bit switch and LED wiring with a memory-mapped port of configurable width. Switch inputs are synchronised and debounced, and change events are latched into sticky flags. A maskable interrupt output is provided. The block sits on the SCIC data bus, beside data memory, and drives the board LEDs.

## Interface
Parameters:
- `SW_WIDTH`, default 4: number of switch inputs, range 1..32.
- `LED_WIDTH`, default 4: number of LED outputs, range 1..32.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a switch change is accepted; must be ≥1.

Ports:
- `clock` input 1: single clock for the whole block.
- `reset` input 1: asynchronous, active-low reset.
- `switches` input SW_WIDTH: raw, asynchronous switch levels.
- `addr` input 2: register select.
- `wr_en` input 1: write strobe, one cycle per write.
- `rd_en` input 1: read strobe, one cycle per read.
- `wdata` input 32: write data.
- `rdata` output 32: read data, zero-extended.
- `rdata_valid` output 1: pulses high for one cycle with `rdata`.
- `LEDs` output LED_WIDTH: LED drive, equal to the LED register.
- `irq` output 1: high while `|(CHANGE & MASK)`.

## Operation
- Register map:
  - 0 `SW_STATE`, RO: debounced switch levels.
  - 1 `LED`, RW: LED register.
  - 2 `CHANGE`, W1C: sticky per-bit change flags.
  - 3 `MASK`, RW: per-bit interrupt enable, SW_WIDTH bits.
- Synchroniser: 2-flop chain per switch bit (`sync1` → `sync2`).
- Debounce, per bit, with counter width `$clog2(DEBOUNCE_CYCLES+1)`:
  - if `sync2 == sw_state[i]`: counter clears to 0.
  - else if counter == DEBOUNCE_CYCLES-1: `sw_state[i] <= sync2[i]`, counter clears, `CHANGE[i]` sets.
  - else: counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles leaves `sw_state` unchanged, because the counter clears when the levels re-match.
- Writes:
  - Bits of `wdata` above the register width are ignored.
  - Writes to `SW_STATE` are ignored.
  - A CHANGE write clears the flag bits where `wdata` is 1.
- Set/clear collision: if a debounce event and a W1C clear hit the same CHANGE bit in the same cycle, set wins and the bit stays 1.
- Reads:
  - `rd_en` registers `rdata` and `rdata_valid` at the next edge.
  - With `rd_en` and `wr_en` in the same cycle on the same address, the read returns the pre-write value.
  - When there is no read, `rdata_valid` is 0 and `rdata` holds its last value.
- `irq` is combinational from the CHANGE and MASK registers only. It has no path from the bus inputs.

## Timing
- Reset values (applied asynchronously on `reset` low): `LEDs`=0, `rdata`=0, `rdata_valid`=0, `irq`=0. All internal state is 0: sync flops, counters, SW_STATE, CHANGE, MASK.
- The first edge after `reset` rises operates normally. Any switch level that is already high debounces in like an ordinary change and sets CHANGE.
- Switch latency, for a change that is stable before edge 1:
  - `sync2` updates at edge 2.
  - `SW_STATE` and `CHANGE` update at edge 2+DEBOUNCE_CYCLES (edge 6 with the default).
  - `irq` rises in the same cycle if the MASK bit is set.
- `LEDs` update on the edge that samples `wr_en` with addr=1.
- Read latency is 1 cycle.
- Reset mid-debounce discards the counter. The change is then re-accepted after the full latency, counted from the release of reset.

## Configuration
- `SCIC_GPIO_DEBOUNCE_EN` defined:
  - Debounce counters are built as described above.
- `SCIC_GPIO_DEBOUNCE_EN` undefined:
  - No counters are built and `DEBOUNCE_CYCLES` is ignored.
  - `sw_state <= sync2` every cycle.
  - `CHANGE[i]` sets whenever `sync2[i] != sw_state[i]`.
  - Switch latency becomes 3 edges.

## Test plan
- Reset defaults and LED write/read:
  - Hold `reset` low, then release. Expect `LEDs`=0 and `irq`=0.
  - Write addr1 ← 0xFFFF_FFF5. Expect `LEDs`=4'h5 from the next cycle.
  - Read addr1. Expect `rdata`=0x0000_0005 with `rdata_valid` high exactly one cycle later.
- Debounce accept:
  - With default parameters and MASK=0x1, drive `switches` 0→4'b0001 before edge 1.
  - Expect SW_STATE=1, CHANGE=1 and `irq`=1 at edge 6 (edge 3 with the macro undefined).
- Glitch reject, macro defined:
  - Pulse `switches[2]` high for 3 cycles.
  - Expect SW_STATE, CHANGE and `irq` all unchanged.
- W1C and set-wins collision:
  - Start with CHANGE=4'b0011. Write addr2 ← 0x1. Expect CHANGE=4'b0010.
  - Then issue a W1C of bit1 in the same cycle that bit1 debounces again. Expect CHANGE[1]=1.
- Mask gating:
  - Set CHANGE=4'b0100 with MASK=0. Expect `irq`=0.
  - Write MASK=4'b0100. Expect `irq`=1 the cycle after the write edge.
- Async reset mid-operation:
  - Assert `reset` low between clock edges, at debounce count 2.
  - Expect all outputs 0 immediately.
  - Release reset with the switch held. Expect SW_STATE to update at edge 6 after release.
